// File: rtl/ula_result_router_if.sv
// ula_result_router_if: result-in / PC, RF and memory-out bundle of the ALUOut router.
interface ula_result_router_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ula_result;
    logic [1:0]  dest;
    logic [4:0]  rd_addr;
    logic        pc_wr;
    logic [31:0] pc_data;
    logic        rf_wr;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        busy;
    modport master (
        output in_valid, ula_result, dest, rd_addr, mem_ack,
        input  in_ready, pc_wr, pc_data, rf_wr, rf_waddr, rf_wdata, mem_req, mem_addr, busy
    );
    modport slave (
        input  in_valid, ula_result, dest, rd_addr, mem_ack,
        output in_ready, pc_wr, pc_data, rf_wr, rf_waddr, rf_wdata, mem_req, mem_addr, busy
    );
endinterface

// File: rtl/ula_result_router.sv
// ula_result_router: 2-entry ALUOut queue delivering each result to PC, RF or memory in order.
// Optional ULA_RESULT_ROUTER_R0_GUARD_EN turns RF writes to r0 into discards.
module ula_result_router (
    input logic clk,
    input logic reset,
    ula_result_router_if.slave bus
);
    localparam int DEPTH = 2;
    localparam logic [1:0] ISSUE_PC = 2'd0, ISSUE_RF = 2'd1, MEM_WAIT = 2'd2, DISCARD = 2'd3;
    logic [31:0] q_data [DEPTH];
    logic [1:0]  q_dest [DEPTH];
    logic [4:0]  q_rd   [DEPTH];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic [1:0]  state;
    logic        has_head, push, pop;
    logic [31:0] head_data;
    assign has_head  = count != 2'd0;
    assign head_data = q_data[rd_ptr];
`ifdef ULA_RESULT_ROUTER_R0_GUARD_EN
    assign state = (q_dest[rd_ptr] == ISSUE_RF && q_rd[rd_ptr] == 5'd0) ? DISCARD : q_dest[rd_ptr];
`else
    assign state = q_dest[rd_ptr];
`endif
    assign bus.in_ready = count < 2'd2;
    assign bus.busy     = has_head;
    assign push = bus.in_valid && bus.in_ready;
    // a memory head only leaves when the memory side takes the address
    assign pop  = has_head && (state != MEM_WAIT || bus.mem_ack);
    always_comb begin
        bus.pc_wr    = has_head && state == ISSUE_PC;
        bus.rf_wr    = has_head && state == ISSUE_RF;
        bus.mem_req  = has_head && state == MEM_WAIT;
        bus.pc_data  = bus.pc_wr ? head_data : 32'd0;
        bus.rf_wdata = bus.rf_wr ? head_data : 32'd0;
        bus.rf_waddr = bus.rf_wr ? q_rd[rd_ptr] : 5'd0;
        bus.mem_addr = bus.mem_req ? head_data : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= 32'd0;
                q_dest[i] <= 2'd0;
                q_rd[i]   <= 5'd0;
            end
        end else begin
            if (push) begin
                q_data[wr_ptr] <= bus.ula_result;
                q_dest[wr_ptr] <= bus.dest;
                q_rd[wr_ptr]   <= bus.rd_addr;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_ula_result_router.sv
// tb_ula_result_router: directed plan sequences plus random traffic against a queue-based model.
module tb_ula_result_router;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    logic [38:0] mq[$];

    ula_result_router_if bus();
    ula_result_router dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] head_kind();
        logic [1:0] k;
        k = mq[0][38:37];
`ifdef ULA_RESULT_ROUTER_R0_GUARD_EN
        if (k == 2'd1 && mq[0][36:32] == 5'd0) k = 2'd3;
`endif
        return k;
    endfunction

    task automatic check_outputs();
        logic [1:0] k;
        logic [31:0] d;
        logic [4:0] rd;
        logic e;
        e  = mq.size() > 0;
        k  = e ? head_kind() : 2'd3;
        d  = e ? mq[0][31:0] : 32'd0;
        rd = e ? mq[0][36:32] : 5'd0;
        check("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
        check("busy", 32'(bus.busy), 32'(e));
        check("pc_wr", 32'(bus.pc_wr), 32'(e && k == 2'd0));
        check("pc_data", bus.pc_data, (e && k == 2'd0) ? d : 32'd0);
        check("rf_wr", 32'(bus.rf_wr), 32'(e && k == 2'd1));
        check("rf_waddr", 32'(bus.rf_waddr), (e && k == 2'd1) ? 32'(rd) : 32'd0);
        check("rf_wdata", bus.rf_wdata, (e && k == 2'd1) ? d : 32'd0);
        check("mem_req", 32'(bus.mem_req), 32'(e && k == 2'd2));
        check("mem_addr", bus.mem_addr, (e && k == 2'd2) ? d : 32'd0);
    endtask

    // one clock: check current outputs, drive inputs, advance model at the edge
    task automatic step(input logic v, input logic [1:0] d, input logic [4:0] rd,
                        input logic [31:0] r, input logic ack);
        logic acc, pop;
        check_outputs();
        bus.in_valid = v; bus.dest = d; bus.rd_addr = rd; bus.ula_result = r; bus.mem_ack = ack;
        acc = v && mq.size() < 2;
        pop = mq.size() > 0 && (head_kind() != 2'd2 || ack);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({d, rd, r});
        @(negedge clk);
    endtask

    task automatic do_reset(input logic ack);
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.mem_ack = ack;
        @(posedge clk);
        mq.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.dest = 2'd0; bus.rd_addr = 5'd0;
        bus.ula_result = 32'd0; bus.mem_ack = 1'b0;
        @(negedge clk);
        do_reset(1'b0);
        idle(1);
        step(1'b1, 2'd0, 5'd0, 32'h0000_0040, 1'b0);
        idle(2);
        step(1'b1, 2'd2, 5'd0, 32'h1000_0008, 1'b0);
        idle(2);
        step(1'b1, 2'd1, 5'd9, 32'hDEAD_BEEF, 1'b0);
        step(1'b1, 2'd0, 5'd0, 32'hAAAA_AAAA, 1'b0);
        step(1'b1, 2'd1, 5'd7, 32'hAAAA_AAAA, 1'b0);
        step(1'b0, 2'd0, 5'd0, 32'd0, 1'b1);
        idle(2);
        step(1'b1, 2'd1, 5'd3, 32'h1, 1'b0);
        step(1'b1, 2'd0, 5'd0, 32'h2, 1'b0);
        step(1'b1, 2'd3, 5'd0, 32'h3, 1'b0);
        idle(2);
        step(1'b1, 2'd1, 5'd0, 32'h55, 1'b0);
        idle(2);
        step(1'b1, 2'd2, 5'd0, 32'h100, 1'b0);
        step(1'b1, 2'd2, 5'd0, 32'h104, 1'b0);
        idle(1);
        do_reset(1'b0);
        step(1'b0, 2'd0, 5'd0, 32'd0, 1'b1);
        idle(1);
        step(1'b1, 2'd2, 5'd0, 32'h200, 1'b0);
        step(1'b1, 2'd1, 5'd4, 32'h300, 1'b1);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) do_reset(1'($urandom));
            else step(1'($urandom_range(2) != 0), 2'($urandom), 5'($urandom),
                      $urandom, $urandom_range(2) == 0);
        end
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ula_result_router.md
# ula_result_router

Result-side counterpart of the ALU operand-select path: captures each 32-bit Ula32 result with its destination tag into a 2-entry queue (the ALUOut buffer), then delivers it to exactly one consumer: PC write, register-file write, or memory-address request. Sits between Ula32 and the PC, register bank and memory interface of the multicycle datapath. Memory requests use a req/ack handshake, so the ALU can run ahead of a stalled memory.

## Interface
- DEPTH, 2, queue entries; fixed at 2, the only supported value
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears queue and all outputs
- in_valid  in  1  result and tag valid this cycle
- in_ready  out  1  queue can accept; equals (count < 2)
- ula_result  in  32  Ula32 output
- dest  in  2  00 = PC, 01 = register file, 10 = memory address, 11 = discard
- rd_addr  in  5  register-file destination (used only when dest = 01)
- pc_wr  out  1  one-cycle PC write strobe
- pc_data  out  32  value for PC
- rf_wr  out  1  one-cycle register-file write strobe
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- mem_req  out  1  memory-address request, held until acknowledged
- mem_addr  out  32  memory address
- mem_ack  in  1  memory accepts mem_addr this cycle
- busy  out  1  queue non-empty

## Operation
- Push: in_valid && in_ready at a rising edge writes {dest, rd_addr, ula_result} at the tail. in_valid while in_ready = 0 is ignored; the producer must hold it.
- Head state machine, evaluated on the head entry while count > 0:
  - ISSUE_PC: pc_wr = 1 and pc_data = head result. Pop at the end of the cycle.
  - ISSUE_RF: rf_wr = 1, rf_waddr = head rd, rf_wdata = head result. Pop at the end of the cycle.
  - MEM_WAIT: mem_req = 1 and mem_addr = head result, held stable. Pop on the edge where mem_ack = 1. mem_ack while mem_req = 0 is ignored.
  - DISCARD: no strobe. Pop at the end of the cycle.
- Delivery is in-order. At most one strobe or request is active per cycle.
- With count = 0, all strobes are 0 and all data outputs are 0.
- Push and pop in the same cycle is legal, and count is unchanged. At count = 2, in_ready = 0 even if a pop occurs that cycle; there is no combinational ready path.
- Pointers wrap modulo 2. count is 2 bits with range 0..2.
- Results pass through unmodified: 32 bits in, 32 bits out, no sign or width conversion.

## Timing
- Reset values: in_ready = 1, busy = 0, pc_wr = rf_wr = mem_req = 0, all data buses 0, count = 0.
- Latency: an entry accepted at edge N drives its strobe or request in the cycle after edge N, provided it is at the head.
- PC, RF and discard entries each occupy the head for exactly 1 cycle. A memory entry occupies it for 1 + (cycles until mem_ack).
- mem_ack in the first request cycle gives 1-cycle occupancy, and the next entry issues in the following cycle.
- Reset mid-operation, including while mem_req is high: everything is flushed. mem_req is 0 in the cycle after the reset edge, and the pending request is dropped without ack.
- in_ready and busy are decoded directly from count, with no extra delay.

## Configuration
- Macro: ULA_RESULT_ROUTER_R0_GUARD_EN.
- Defined: an RF entry with rd = 0 is treated as DISCARD. rf_wr stays 0, and the entry still pops after 1 cycle.
- Undefined: an RF entry with rd = 0 asserts rf_wr with rf_waddr = 0, and the register file is responsible for ignoring it.

## Test plan
- Reset, then push {PC, 0x0000_0040} → pc_wr = 1 with pc_data = 0x0000_0040 exactly one cycle after acceptance. busy then returns to 0 and in_ready stays 1.
- Push {MEM, 0x1000_0008}, hold mem_ack = 0 for 3 cycles, push {RF, rd = 9, 0xDEAD_BEEF} → mem_req stays high with a stable address.
  - Count reaches 2 and in_ready = 0.
  - mem_ack pops the MEM entry.
  - Next cycle: rf_wr = 1, rf_waddr = 9, rf_wdata = 0xDEAD_BEEF.
- Back-to-back pushes {RF, rd = 3, 0x1}, {PC, 0x2}, {DISCARD, 0x3} → one strobe per cycle in order: rf_wr, then pc_wr, then a cycle with none. Count never exceeds 1.
- Push {RF, rd = 0, 0x55} → with the macro defined, rf_wr stays 0. Without it, rf_wr = 1 with rf_waddr = 0.
- Fill the queue with two MEM entries, then assert reset while mem_req = 1 → next cycle mem_req = 0, count = 0, in_ready = 1. A late mem_ack has no effect.
- Push while in_ready = 0 with distinct data 0xAAAA_AAAA → that value never appears on any output.
